seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the seven-segment display driver.
- Samples the multiplexed, active-low segment and anode lines and debounces each digit slot.
- Decodes each segment pattern back to a 4-bit hex value and assembles a full 8-digit frame.
- Used as an on-chip display monitor and as a scoreboard source for display-path verification.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table, blank codes and scan FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_NONE   = 8'hFF;

    // Active-low segments, bit 6 = A ... bit 0 = G; index is the hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_e;

    function automatic logic onehot_low(input logic [7:0] an);
        int unsigned zeros;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) zeros++;
        end
        return zeros == 1;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounces multiplexed seven-segment scan lines and rebuilds 8-digit hex frames.
// Optional SEG7_SCAN_CHANGE_DET_EN adds frame_changed, flagging frames that differ from the last.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    err_seg,
    output logic                    err_anode
`ifdef SEG7_SCAN_CHANGE_DET_EN
    ,
    output logic                    frame_changed
`endif
);

    localparam logic [8:0] STABLE = 9'(STABLE_CYCLES);

    state_e                  state_q, state_d;
    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   an_q, an_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [8:0]              cnt_inc;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [3:0]              digit_q [NUM_DIGITS];
    logic [3:0]              digit_d [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] digits_flat;
    logic                    same, eval, frame_load, an_ok, glyph_hit;
    logic                    err_seg_d, err_anode_d;
    logic [3:0]              glyph_nib;
    logic [2:0]              an_idx;

    seg7_glyph_decode u_glyph (
        .seg    (seg_q),
        .hit    (glyph_hit),
        .nibble (glyph_nib)
    );

    always_comb begin
        an_ok  = onehot_low(an_q);
        an_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) an_idx = 3'(i);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_flat[4*i +: 4] = digit_q[i];
        end
    end

    // cnt_q counts identical samples seen so far; capture fires as the count hits STABLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        same    = (seg_q == seg_prev_q) && (an_q == an_prev_q);
        cnt_inc = {1'b0, cnt_q} + 9'd1;
        unique case (state_q)
            S_IDLE: begin
                if (an_q != AN_NONE) begin
                    state_d = S_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            S_SETTLE: begin
                if (!same) begin
                    cnt_d = 8'd1;
                    if (an_q == AN_NONE) state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (cnt_inc >= STABLE) begin
                        eval    = 1'b1;
                        state_d = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!same) begin
                    cnt_d   = 8'd1;
                    state_d = (an_q == AN_NONE) ? S_IDLE : S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame hand-off clears the mask first so a same-cycle capture lands in the new frame.
    always_comb begin
        mask_d      = mask_q;
        digit_d     = digit_q;
        err_seg_d   = 1'b0;
        err_anode_d = 1'b0;
        frame_load  = (mask_q == '1);
        if (frame_load) mask_d = '0;
        if (eval) begin
            if (!an_ok) begin
                err_anode_d = 1'b1;
            end else if (!glyph_hit) begin
                err_seg_d = 1'b1;
            end else begin
                digit_d[an_idx] = glyph_nib;
                mask_d[an_idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seg_q       <= SEG_BLANK;
            seg_prev_q  <= SEG_BLANK;
            an_q        <= AN_NONE;
            an_prev_q   <= AN_NONE;
            cnt_q       <= 8'd0;
            mask_q      <= '0;
            digit_q     <= '{default: 4'h0};
            frame_valid <= 1'b0;
            frame_data  <= '0;
            err_seg     <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg;
            seg_prev_q  <= seg_q;
            an_q        <= an;
            an_prev_q   <= an_q;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            digit_q     <= digit_d;
            frame_valid <= frame_load;
            err_seg     <= err_seg_d;
            err_anode   <= err_anode_d;
            if (frame_load) frame_data <= digits_flat;
        end
    end

`ifdef SEG7_SCAN_CHANGE_DET_EN
    // frame_data still holds the previous frame when the new one is loaded.
    logic first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q       <= 1'b1;
            frame_changed <= 1'b0;
        end else begin
            frame_changed <= frame_load && (first_q || (digits_flat != frame_data));
            if (frame_load) first_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (STABLE_CYCLES = 4).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [7:0]  an = 8'hFF;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        err_seg;
    logic        err_anode;
`ifdef SEG7_SCAN_CHANGE_DET_EN
    logic        frame_changed;
    logic        last_changed = 1'b0;
`endif

    localparam logic [6:0] GL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_decoder #(
        .STABLE_CYCLES (4),
        .NUM_DIGITS    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg           (seg),
        .an            (an),
        .frame_valid   (frame_valid),
        .frame_data    (frame_data),
        .err_seg       (err_seg),
        .err_anode     (err_anode)
`ifdef SEG7_SCAN_CHANGE_DET_EN
        ,
        .frame_changed (frame_changed)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_valid = 0;
    int          n_eseg = 0;
    int          n_eanode = 0;
    logic [31:0] last_frame = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                n_valid++;
                last_frame = frame_data;
`ifdef SEG7_SCAN_CHANGE_DET_EN
                last_changed = frame_changed;
`endif
            end
            if (err_seg) n_eseg++;
            if (err_anode) n_eanode++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic send(input int i, input int v);
        put(~(8'd1 << i), GL[v], 10);
    endtask

    task automatic blank(input int n);
        put(8'hFF, 7'h7F, n);
    endtask

    int v0, s0, a0, first;

    initial begin
        step(2);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_data", frame_data, 0);
        check("rst_eseg", 32'(err_seg), 0);
        check("rst_eanode", 32'(err_anode), 0);
        rst_n = 1'b1;
        blank(3);

        // Full frame 0..7
        v0 = n_valid; s0 = n_eseg; a0 = n_eanode;
        for (int i = 0; i < 8; i++) send(i, i);
        blank(4);
        check("t1_nvalid", n_valid - v0, 1);
        check("t1_frame", last_frame, 32'h76543210);
        check("t1_held", frame_data, 32'h76543210);
        check("t1_eseg", n_eseg - s0, 0);
        check("t1_eanode", n_eanode - a0, 0);
`ifdef SEG7_SCAN_CHANGE_DET_EN
        check("t1_changed", 32'(last_changed), 1);
`endif

        // Unstable pattern on anode 0 must not capture
        v0 = n_valid; s0 = n_eseg; a0 = n_eanode;
        for (int k = 0; k < 5; k++) begin
            put(8'hFE, GL[0], 2);
            put(8'hFE, GL[1], 2);
        end
        for (int i = 1; i < 8; i++) send(i, i);
        blank(4);
        check("t2_nofrm", n_valid - v0, 0);
        check("t2_noerr", (n_eseg - s0) + (n_eanode - a0), 0);
        send(0, 9);
        blank(4);
        check("t2_nvalid", n_valid - v0, 1);
        check("t2_frame", last_frame, 32'h76543219);

        // Two anodes low: one err_anode, latency STABLE+1
        v0 = n_valid; a0 = n_eanode;
        an = 8'hFC; seg = GL[0]; first = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (err_anode && first == 0) first = n;
        end
        blank(4);
        check("t3_latency", first, 5);
        check("t3_eanode", n_eanode - a0, 1);
        check("t3_nofrm", n_valid - v0, 0);

        // Non-glyph on anode 2: one err_seg, slot 2 stays empty
        v0 = n_valid; s0 = n_eseg; a0 = n_eanode;
        put(8'hFB, 7'b1111110, 6);
        blank(3);
        check("t4_eseg", n_eseg - s0, 1);
        check("t4_eanode", n_eanode - a0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 2) send(i, 15 - i);
        end
        blank(4);
        check("t4_nofrm", n_valid - v0, 0);
        send(2, 12);
        blank(4);
        check("t4_nvalid", n_valid - v0, 1);
        check("t4_frame", last_frame, 32'h89ABCCEF);

        // Reset mid-frame discards captured digits
        for (int i = 0; i < 5; i++) send(i, 5);
        rst_n = 1'b0;
        #1;
        check("t5_async_data", frame_data, 0);
        step(2);
        check("t5_rst_valid", 32'(frame_valid), 0);
        check("t5_rst_errs", 32'({err_seg, err_anode}), 0);
        rst_n = 1'b1;
        blank(3);
        v0 = n_valid;
        for (int i = 5; i < 8; i++) send(i, 15);
        blank(4);
        check("t5_nofrm", n_valid - v0, 0);
        for (int i = 0; i < 5; i++) send(i, 15);
        blank(4);
        check("t5_nvalid", n_valid - v0, 1);
        check("t5_frame", last_frame, 32'hFFFFFFFF);

`ifdef SEG7_SCAN_CHANGE_DET_EN
        for (int i = 0; i < 8; i++) send(i, i);
        blank(4);
        check("t6_chg_a", 32'(last_changed), 1);
        for (int i = 0; i < 8; i++) send(i, i);
        blank(4);
        check("t6_chg_b", 32'(last_changed), 0);
        send(0, 1);
        for (int i = 1; i < 8; i++) send(i, i);
        blank(4);
        check("t6_chg_c", 32'(last_changed), 1);
        check("t6_frame", last_frame, 32'h76543211);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        blank(3);
        for (int i = 0; i < 8; i++) send(i, 0);
        blank(4);
        check("t6_first", 32'(last_changed), 1);
        check("t6_zero", last_frame, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
